// File: rtl/result_serializer_if.sv
// Valid/ready element stream carrying a matrix element and its (row, col) tag.
// master drives data/valid/row/col/last and samples ready; slave is the consumer.
interface result_serializer_if #(
  parameter int DW = 16,
  parameter int RW = 2,
  parameter int CW = 2
);
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic          out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_row,
    output out_col,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_row,
    input  out_col,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/result_serializer.sv
// Snapshots a ROWS x COLS result matrix on load and streams it row-major over a valid/ready bus.
// Ports: clk, reset (sync, active-high), d_in/load capture side, m_out stream, busy/frame_done/overflow status.
module result_serializer #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DW   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ROWS*COLS*DW-1:0] d_in,
  input  logic                   load,
  result_serializer_if.master    m_out,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   overflow
);

  localparam int N  = ROWS * COLS;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [KW-1:0] K_LAST = KW'(N - 1);
  localparam logic [CW-1:0] C_LAST = CW'(COLS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [KW-1:0]   r_k;
  logic [KW-1:0]   w_k_nxt;
  logic [RW-1:0]   r_row;
  logic [RW-1:0]   w_row_nxt;
  logic [CW-1:0]   r_col;
  logic [CW-1:0]   w_col_nxt;
  logic [N*DW-1:0] r_data;
  logic            r_fd;
  logic            w_fd_nxt;
  logic            r_ovf;
  logic            w_ovf_nxt;
  logic            w_capture;
  logic            w_hs;
  logic            w_last;

  assign w_hs   = (r_state == SEND) && m_out.out_ready;
  assign w_last = (r_k == K_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_fd_nxt    = 1'b0;
    w_ovf_nxt   = r_ovf;
    w_capture   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (load) begin
          w_state_nxt = SEND;
          w_capture   = 1'b1;
          w_k_nxt     = '0;
          w_row_nxt   = '0;
          w_col_nxt   = '0;
        end
      end
      SEND: begin
        if (w_hs && w_last) begin
          // A load coinciding with the final handshake chains frames
          // back-to-back without a bubble.
          w_fd_nxt  = 1'b1;
          w_k_nxt   = '0;
          w_row_nxt = '0;
          w_col_nxt = '0;
          if (load) begin
            w_capture = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          if (w_hs) begin
            w_k_nxt = r_k + 1'b1;
            if (r_col == C_LAST) begin
              w_col_nxt = '0;
              w_row_nxt = r_row + 1'b1;
            end else begin
              w_col_nxt = r_col + 1'b1;
            end
          end
          if (load) begin
            w_ovf_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_data  <= '0;
      r_fd    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      r_fd    <= w_fd_nxt;
      r_ovf   <= w_ovf_nxt;
      if (w_capture) begin
        r_data <= d_in;
      end
    end
  end

  assign m_out.out_valid = (r_state == SEND);
  assign m_out.out_data  = r_data[r_k*DW +: DW];
  assign m_out.out_row   = r_row;
  assign m_out.out_col   = r_col;
  assign m_out.out_last  = (r_state == SEND) && w_last;

  assign busy       = (r_state == SEND);
  assign frame_done = r_fd;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_result_serializer.sv
// Randomised and directed bench for result_serializer with a frame-level model and scoreboard.
// Model pushes expected elements on accepted loads; a negedge monitor pops on each handshake.
module tb_result_serializer;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int DW   = 16;
  localparam int N    = ROWS * COLS;
  localparam int RW   = 2;
  localparam int CW   = 2;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [RW-1:0] r;
    logic [CW-1:0] c;
    logic          l;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            load = 1'b1;
  logic            ready = 1'b1;
  logic [N*DW-1:0] d_in = '0;
  logic            busy;
  logic            frame_done;
  logic            overflow;

  result_serializer_if #(.DW(DW), .RW(RW), .CW(CW)) bus ();

  assign bus.out_ready = ready;

  result_serializer #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .d_in       (d_in),
    .load       (load),
    .m_out      (bus),
    .busy       (busy),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  int   m_rem  = 0;
  bit   m_fd   = 0;
  bit   m_ovf  = 0;
  bit   m_hs   = 0;
  bit   chk_en = 0;
  exp_t e;
  exp_t cur;
  exp_t prev_o;
  bit   prev_stall = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level reference: a frame is N tagged elements; a load is taken
  // only when no element of the current frame remains after this edge.
  always @(posedge clk) begin
    if (reset) begin
      sb.delete();
      m_rem  = 0;
      m_fd   = 0;
      m_ovf  = 0;
      chk_en = 1;
    end else if (chk_en) begin
      m_hs = (m_rem > 0) && ready;
      if (m_hs) m_rem--;
      m_fd = m_hs && (m_rem == 0);
      if (load) begin
        if (m_rem == 0) begin
          for (int k = 0; k < N; k++) begin
            e.d = d_in[k*DW +: DW];
            e.r = RW'(k / COLS);
            e.c = CW'(k % COLS);
            e.l = (k == N - 1);
            sb.push_back(e);
          end
          m_rem = N;
        end else begin
          m_ovf = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 64'(bus.out_valid), 64'(m_rem > 0));
      chk("busy", 64'(busy), 64'(m_rem > 0));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("frame_done", 64'(frame_done), 64'(m_fd));
      cur = {bus.out_data, bus.out_row, bus.out_col, bus.out_last};
      if (prev_stall) begin
        chk("stall_valid", 64'(bus.out_valid), 64'(1));
        chk("stall_hold", 64'(cur), 64'(prev_o));
      end
      if (bus.out_valid && ready) begin
        if (sb.size() == 0) begin
          chk("sb_nonempty", 64'(0), 64'(1));
        end else begin
          e = sb.pop_front();
          chk("element", 64'(cur), 64'(e));
        end
      end
      prev_stall = bus.out_valid && !ready && !reset;
      prev_o     = cur;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int mode);
    logic [3:0] pat;
    int cnt;
    pat = 4'b1001;
    cnt = 0;
    load = 1'b0;
    while (m_rem > 0 && cnt < 300) begin
      if (mode == 0) ready = 1'b1;
      else if (mode == 1) ready = pat[cnt % 4];
      else ready = 1'($urandom % 2);
      step();
      cnt++;
    end
    chk("drain_bound", 64'(m_rem), 64'(0));
    ready = 1'b1;
    repeat (3) step();
  endtask

  logic [N*DW-1:0] fA;
  logic [N*DW-1:0] fB;
  logic [N*DW-1:0] fX;
  logic [3:0]      pat;
  bit              done;
  int              cnt;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < N; k++) begin
      fA[k*DW +: DW] = DW'(k + 1);
      fB[k*DW +: DW] = DW'(16'h0100 + k);
      fX[k*DW +: DW] = 16'hBEEF;
    end
    pat = 4'b1001;

    // load held high during reset must be ignored
    d_in = fA;
    repeat (3) step();
    reset = 1'b0;
    load  = 1'b1;
    step();
    drain(0);

    // ready pattern 1,0,0,1
    load = 1'b1;
    d_in = fA;
    step();
    drain(1);

    // overflow: second load while element 3 pending
    load = 1'b1;
    d_in = fA;
    step();
    done = 0;
    cnt  = 0;
    while (m_rem > 0 && cnt < 300) begin
      ready = pat[cnt % 4];
      if (!done && m_rem == 13) begin
        load = 1'b1;
        d_in = fX;
        done = 1;
      end else begin
        load = 1'b0;
      end
      step();
      cnt++;
    end
    chk("ovf_drain_bound", 64'(m_rem), 64'(0));
    load = 1'b0;
    ready = 1'b1;
    repeat (3) step();

    // back-to-back load on the last handshake
    load = 1'b1;
    d_in = fA;
    step();
    done = 0;
    cnt  = 0;
    while (m_rem > 0 && cnt < 300) begin
      if (!done && m_rem == 1) begin
        load = 1'b1;
        d_in = fB;
        done = 1;
      end else begin
        load = 1'b0;
      end
      step();
      cnt++;
    end
    chk("b2b_drain_bound", 64'(m_rem), 64'(0));
    load = 1'b0;
    repeat (3) step();

    // reset while element 5 pending
    load = 1'b1;
    d_in = fA;
    step();
    load = 1'b0;
    cnt  = 0;
    while (m_rem != 11 && cnt < 50) begin
      step();
      cnt++;
    end
    chk("rst_pos_bound", 64'(m_rem), 64'(11));
    ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    ready = 1'b1;
    repeat (2) step();
    load = 1'b1;
    d_in = fB;
    step();
    drain(0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom % 100) == 0;
      load  = ($urandom % 6) == 0;
      ready = 1'($urandom % 2);
      for (int k = 0; k < N; k++) d_in[k*DW +: DW] = DW'($urandom);
      step();
    end
    reset = 1'b0;
    drain(2);

    chk("sb_empty_end", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/result_serializer.md
Name: result_serializer

Overview:
- Drain stage directly downstream of the result capture buffer in the systolic-array matrix-multiply datapath.
- On a one-cycle load pulse, it snapshots the full flattened result matrix (ROWS x COLS elements of DW bits).
- It then streams the elements one per handshake over a valid/ready interface, in row-major order, tagged with row/col indices and a last flag.
- It decouples the single-cycle `done` strobe of the capture buffer from a back-pressured consumer (e.g. output FIFO or host readback).

Parameters:
- ROWS, 4, number of result matrix rows (>=1)
- COLS, 4, number of result matrix columns (>=1)
- DW, 16, bits per result element (>=1)

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- d_in  input  ROWS*COLS*DW  flattened matrix; element k = d_in[k*DW +: DW], k = r*COLS + c
- load  input  1  capture strobe (driven by upstream buffer done)
- out_data  output  DW  current element
- out_valid  output  1  out_data/out_row/out_col/out_last valid
- out_ready  input  1  consumer accepts when out_valid && out_ready
- out_row  output  max(1,$clog2(ROWS))  row index of current element
- out_col  output  max(1,$clog2(COLS))  column index of current element
- out_last  output  1  current element is k = ROWS*COLS-1
- busy  output  1  frame held and not fully drained
- frame_done  output  1  one-cycle pulse after last element accepted
- overflow  output  1  sticky: load arrived while busy and was dropped

Behaviour:
- Reset (synchronous, active-high, clock clk): all outputs 0; state IDLE; index 0; capture register cleared. `load` is ignored while reset is high. Reset mid-frame aborts the frame with no frame_done.
- FSM states:
  - IDLE: busy=0, out_valid=0.
  - SEND: busy=1, out_valid=1.
- IDLE -> SEND: on `load`, capture d_in into internal register, set index k=0.
  - Load at edge t gives out_valid=1 with element 0 in cycle t+1. Fixed latency is 1 cycle.
- SEND, handshake (out_valid && out_ready) with k < ROWS*COLS-1: k increments. Next element is presented the following cycle.
  - Throughput is 1 element/cycle when out_ready is held high.
- SEND, no handshake: out_data, out_row, out_col and out_last are held stable. out_valid never drops without a handshake.
- SEND, handshake on last element:
  - If load is not asserted in the same cycle: go to IDLE, out_valid=0 next cycle, frame_done=1 for exactly that one cycle.
  - If load is asserted in the same cycle: capture new d_in, k=0, stay in SEND. The new element 0 is presented next cycle (no bubble) and frame_done still pulses.
- Load in SEND other than on the last handshake: ignored; the captured data is not disturbed. overflow is set to 1 and stays 1 until reset.
- Index mapping (combinational from k): out_row = k / COLS, out_col = k % COLS, out_data = captured[k*DW +: DW]. Indices never exceed ROWS-1 / COLS-1. k wraps only by returning to 0 on a new frame.
- d_in is sampled only on an accepted load. Changes to d_in at other times have no effect.
- out_data, out_row, out_col and out_last are registered or derived from registered k and register data. There is no combinational path from out_ready to out_valid.
- Degenerate case ROWS=COLS=1: the single element has out_last=1 on its first valid cycle.

Test Plan:
- Defaults, element k = k+1 (0x0001..0x0010), load one cycle, out_ready=1 -> out_valid for 16 consecutive cycles starting 1 cycle after load; data 0x0001..0x0010; (row,col) = (0,0),(0,1)..(3,3); out_last only on 0x0010; frame_done pulse in the cycle after; busy=0 thereafter.
- Same frame, out_ready pattern 1,0,0,1 repeating -> every element appears exactly once in order; outputs stable during stalls; 16 handshakes total; overflow=0.
- Load second frame (all 0xBEEF) while element 3 is pending -> stream still delivers original 0x0004..0x0010 unchanged; overflow=1 and remains 1 after frame_done.
- Second load (element k = 0x0100+k) asserted in same cycle as handshake of last element -> next cycle out_valid=1, out_data=0x0100, row=0, col=0; frame_done pulses; no out_valid gap.
- Reset asserted while element 5 (0x0006) is pending -> next cycle out_valid=0, busy=0, overflow=0, frame_done=0; a subsequent load restarts at element 0.
- load=1 while reset=1 -> stays IDLE, out_valid=0; load one cycle after reset deasserts -> normal frame.
